// File: rtl/sram_sched_pkg.sv
// Shared widths and constants for the SRAM match scheduler.
package sram_sched_pkg;

    localparam int unsigned NUM_PORTS  = 16;
    localparam int unsigned NUM_SRAMS  = 32;
    localparam int unsigned SRAM_IDX_W = 5;
    localparam int unsigned SRAM_SEL_W = 6;
    localparam int unsigned PORT_IDX_W = 4;
    localparam int unsigned FS_W       = 11;
    localparam int unsigned CNT_W      = 6;

    // Bit 5 set in a best-SRAM selection means "no SRAM chosen"
    localparam logic [SRAM_SEL_W-1:0] SRAM_NONE = 6'd32;

endpackage

// File: rtl/sram_lock_table.sv
// Per-SRAM lock/owner table with lowest-port-wins grant resolution,
// owner-based release and a registered count of locked SRAMs.
module sram_lock_table
    import sram_sched_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_PORTS-1:0]                   match_suc,
    input  logic [NUM_PORTS-1:0][SRAM_SEL_W-1:0]   match_best_sram,
    input  logic [NUM_PORTS-1:0]                   wr_release,
    output logic [NUM_SRAMS-1:0]                   locked,
    output logic [NUM_PORTS-1:0]                   bound,
    output logic [NUM_PORTS-1:0]                   bind_valid,
    output logic [NUM_PORTS-1:0]                   bind_fail,
    output logic [NUM_PORTS-1:0][SRAM_IDX_W-1:0]   bind_sram,
    output logic [CNT_W-1:0]                       locked_count
);

    logic [NUM_SRAMS-1:0][PORT_IDX_W-1:0] owner;
    logic [NUM_SRAMS-1:0][PORT_IDX_W-1:0] owner_n;
    logic [NUM_SRAMS-1:0]                 locked_n;
    logic [NUM_SRAMS-1:0]                 claimed;
    logic [NUM_PORTS-1:0]                 bound_n;
    logic [NUM_PORTS-1:0]                 bind_valid_n;
    logic [NUM_PORTS-1:0]                 bind_fail_n;
    logic [NUM_PORTS-1:0][SRAM_IDX_W-1:0] bind_sram_n;
    logic [CNT_W-1:0]                     locked_count_n;
    logic [SRAM_SEL_W-1:0]                sel;
    logic [SRAM_IDX_W-1:0]                idx;

    // Next lock state: releases and grants both judged against pre-edge state
    always_comb begin
        locked_n       = locked;
        owner_n        = owner;
        bound_n        = bound;
        bind_sram_n    = bind_sram;
        bind_valid_n   = '0;
        bind_fail_n    = '0;
        claimed        = '0;
        sel            = SRAM_NONE;
        idx            = '0;
        locked_count_n = '0;

        for (int s = 0; s < NUM_SRAMS; s++) begin
            if (locked[s] && wr_release[owner[s]]) begin
                locked_n[s]       = 1'b0;
                bound_n[owner[s]] = 1'b0;
            end
        end

        // Ascending port order gives the lowest index priority on a shared SRAM
        for (int p = 0; p < NUM_PORTS; p++) begin
            sel = match_best_sram[p];
            idx = sel[SRAM_IDX_W-1:0];
            if (match_suc[p] && !sel[SRAM_SEL_W-1]) begin
                if (locked[idx] || bound[p] || claimed[idx]) begin
                    bind_fail_n[p] = 1'b1;
                end else begin
                    claimed[idx]    = 1'b1;
                    locked_n[idx]   = 1'b1;
                    owner_n[idx]    = PORT_IDX_W'(p);
                    bound_n[p]      = 1'b1;
                    bind_sram_n[p]  = idx;
                    bind_valid_n[p] = 1'b1;
                end
            end
        end

        for (int s = 0; s < NUM_SRAMS; s++) begin
            locked_count_n = locked_count_n + CNT_W'(locked_n[s]);
        end
    end

    // Lock table registers; reset drops every lock at once
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            locked       <= '0;
            owner        <= '0;
            bound        <= '0;
            bind_sram    <= '0;
            bind_valid   <= '0;
            bind_fail    <= '0;
            locked_count <= '0;
        end else begin
            locked       <= locked_n;
            owner        <= owner_n;
            bound        <= bound_n;
            bind_sram    <= bind_sram_n;
            bind_valid   <= bind_valid_n;
            bind_fail    <= bind_fail_n;
            locked_count <= locked_count_n;
        end
    end

endmodule

// File: rtl/sram_match_scheduler.sv
// Rotating SRAM offer to each write-port matcher, with free-space and
// accessibility muxing on top of the shared lock table.
module sram_match_scheduler
    import sram_sched_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_PORTS-1:0]                   match_enable,
    input  logic [NUM_PORTS-1:0]                   match_suc,
    input  logic [NUM_PORTS-1:0][SRAM_SEL_W-1:0]   match_best_sram,
    input  logic [NUM_PORTS-1:0]                   wr_release,
    input  logic [NUM_SRAMS-1:0][FS_W-1:0]         sram_free_space,
    output logic [NUM_PORTS-1:0][SRAM_IDX_W-1:0]   match_sram,
    output logic [NUM_PORTS-1:0]                   accessible,
    output logic [NUM_PORTS-1:0][FS_W-1:0]         match_free_space,
    output logic [NUM_PORTS-1:0]                   bind_valid,
    output logic [NUM_PORTS-1:0]                   bind_fail,
    output logic [NUM_PORTS-1:0][SRAM_IDX_W-1:0]   bind_sram,
    output logic [NUM_PORTS-1:0]                   bound,
    output logic [CNT_W-1:0]                       locked_count
);

    logic [SRAM_IDX_W-1:0]                scan_offset;
    logic [SRAM_IDX_W-1:0]                scan_next;
    logic [NUM_PORTS-1:0][SRAM_IDX_W-1:0] match_sram_n;
    logic [NUM_SRAMS-1:0]                 locked;

    // Advance the scan; stride-2 spacing keeps the 16 offers distinct mod 32
    always_comb begin
        scan_next = scan_offset + SRAM_IDX_W'(1);
        for (int p = 0; p < NUM_PORTS; p++) begin
            match_sram_n[p] = scan_next + SRAM_IDX_W'(2 * p);
        end
    end

    // Scan counter and offered-index registers; the scan ignores match_enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_offset <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                match_sram[p] <= SRAM_IDX_W'(2 * p);
            end
        end else begin
            scan_offset <= scan_next;
            match_sram  <= match_sram_n;
        end
    end

    // Free-space and accessibility muxes driven from registered state
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            match_free_space[p] = sram_free_space[match_sram[p]];
            accessible[p]       = ~locked[match_sram[p]] & ~bound[p];
        end
    end

    sram_lock_table u_lock_table (
        .clk             (clk),
        .rst_n           (rst_n),
        .match_suc       (match_suc),
        .match_best_sram (match_best_sram),
        .wr_release      (wr_release),
        .locked          (locked),
        .bound           (bound),
        .bind_valid      (bind_valid),
        .bind_fail       (bind_fail),
        .bind_sram       (bind_sram),
        .locked_count    (locked_count)
    );

endmodule
